// File: rtl/mult_array_scheduler_pkg.sv
// Shared definitions for the multiplier-array scheduler.
//   LANES         : filters processed in parallel by the array
//   TAPS          : elements in one input window
//   sched_state_e : controller state encoding
package mult_array_scheduler_pkg;

  localparam int unsigned LANES = 16;
  localparam int unsigned TAPS  = 27;

  typedef enum logic [2:0] {
    StIdle    = 3'd0,
    StLoadW   = 3'd1,
    StFetchX  = 3'd2,
    StFire    = 3'd3,
    StWaitMul = 3'd4,
    StEmit    = 3'd5,
    StDone    = 3'd6,
    StErr     = 3'd7
  } sched_state_e;

endpackage

// File: rtl/mult_array_scheduler_timeout.sv
// Watchdog for the wait on the multiplier array's valid.
//   clk, rst : clock, asynchronous active-low reset
//   clear    : restart the count at zero
//   en       : advance the count by one (saturates at TIMEOUT-1)
//   expired  : count has reached TIMEOUT-1
module mult_timeout_counter #(
  parameter int unsigned TIMEOUT = 64
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic en,
  output logic expired
);

  localparam int unsigned CntW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [CntW-1:0] LastCnt = CntW'(TIMEOUT - 1);

  logic [CntW-1:0] cnt_q, cnt_d;

  assign expired = (cnt_q == LastCnt);

  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = '0;
    end else if (en && !expired) begin
      cnt_d = cnt_q + CntW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/mult_array_scheduler.sv
// Sequencing controller for the 27x16 multiplier array. Per filter group it
// loads a weight set, then for each output pixel fetches a window, fires the
// array, waits for valid and hands the bundle downstream.
//   cfg_start/cfg_num_pixels/cfg_num_groups : layer request and sizes
//   w_req/w_ack     : weight-set fetch handshake
//   x_req/x_ack     : input-window fetch handshake
//   mult_start      : one-cycle array start pulse
//   mult_valid      : array result valid
//   res_valid/res_ready : product bundle handshake to the adder tree
//   pixel_idx/group_idx : current position
//   busy/done/err   : layer status (err is sticky until the next start)
module mult_array_scheduler
  import mult_array_scheduler_pkg::*;
#(
  parameter int unsigned bitsize   = 14,
  parameter int unsigned FRAC_BITS = 7,
  parameter int unsigned PIX_W     = 16,
  parameter int unsigned GRP_W     = 8,
  parameter int unsigned TIMEOUT   = 64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cfg_start,
  input  logic [PIX_W-1:0] cfg_num_pixels,
  input  logic [GRP_W-1:0] cfg_num_groups,
  output logic             w_req,
  input  logic             w_ack,
  output logic             x_req,
  input  logic             x_ack,
  output logic             mult_start,
  input  logic             mult_valid,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [PIX_W-1:0] pixel_idx,
  output logic [GRP_W-1:0] group_idx,
  output logic             busy,
  output logic             done,
  output logic             err
);

  // Element widths only matter to the datapath; reject nonsense configs here.
  if (FRAC_BITS >= bitsize) begin : g_bad_fixed_point
    $error("FRAC_BITS must be smaller than bitsize");
  end

  sched_state_e     state_q, state_d;
  logic [PIX_W-1:0] pixel_q, pixel_d, npx_q, npx_d;
  logic [GRP_W-1:0] group_q, group_d, ngrp_q, ngrp_d;
  logic             busy_q, busy_d, done_q, done_d, err_q, err_d;
  logic             cnt_clear, cnt_en, cnt_expired;

  mult_timeout_counter #(
    .TIMEOUT(TIMEOUT)
  ) u_timeout (
    .clk    (clk),
    .rst    (rst),
    .clear  (cnt_clear),
    .en     (cnt_en),
    .expired(cnt_expired)
  );

  always_comb begin
    state_d   = state_q;
    pixel_d   = pixel_q;
    group_d   = group_q;
    npx_d     = npx_q;
    ngrp_d    = ngrp_q;
    busy_d    = busy_q;
    err_d     = err_q;
    done_d    = 1'b0;
    cnt_clear = 1'b0;
    cnt_en    = 1'b0;

    unique case (state_q)
      StIdle, StErr: begin
        if (cfg_start) begin
          npx_d   = cfg_num_pixels;
          ngrp_d  = cfg_num_groups;
          pixel_d = '0;
          group_d = '0;
          err_d   = 1'b0;
          busy_d  = 1'b1;
          state_d = ((cfg_num_pixels == '0) || (cfg_num_groups == '0)) ? StDone : StLoadW;
        end
      end
      StLoadW: begin
        if (w_ack) state_d = StFetchX;
      end
      StFetchX: begin
        if (x_ack) state_d = StFire;
      end
      StFire: begin
        cnt_clear = 1'b1;
        state_d   = StWaitMul;
      end
      StWaitMul: begin
        if (mult_valid) begin
          state_d = StEmit;
        end else if (cnt_expired) begin
          state_d = StErr;
          err_d   = 1'b1;
          busy_d  = 1'b0;
        end else begin
          cnt_en = 1'b1;
        end
      end
      StEmit: begin
        if (res_ready) begin
          // Counts are nonzero here, so "!= last" is the same as "< last".
          if (pixel_q != npx_q - PIX_W'(1)) begin
            pixel_d = pixel_q + PIX_W'(1);
            state_d = StFetchX;
          end else if (group_q != ngrp_q - GRP_W'(1)) begin
            pixel_d = '0;
            group_d = group_q + GRP_W'(1);
            state_d = StLoadW;
          end else begin
            state_d = StDone;
          end
        end
      end
      StDone: begin
        // done is registered so it lands together with busy falling.
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= StIdle;
      pixel_q <= '0;
      group_q <= '0;
      npx_q   <= '0;
      ngrp_q  <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pixel_q <= pixel_d;
      group_q <= group_d;
      npx_q   <= npx_d;
      ngrp_q  <= ngrp_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  assign w_req      = (state_q == StLoadW);
  assign x_req      = (state_q == StFetchX);
  assign mult_start = (state_q == StFire);
  assign res_valid  = (state_q == StEmit);
  assign pixel_idx  = pixel_q;
  assign group_idx  = group_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign err        = err_q;

endmodule

// File: tb/tb_mult_array_scheduler.sv
module tb_mult_array_scheduler;

  localparam int Lat = 3;

  typedef struct packed {
    logic [7:0]  g;
    logic [15:0] p;
  } exp_t;

  logic        clk, rst, cfg_start;
  logic [15:0] cfg_num_pixels;
  logic [7:0]  cfg_num_groups;
  logic        w_req, w_ack, x_req, x_ack, mult_start, mult_valid;
  logic        res_valid, res_ready, busy, done, err;
  logic [15:0] pixel_idx;
  logic [7:0]  group_idx;

  int   n_checks, n_bad, cyc;
  int   n_w, n_x, n_start, n_hs, n_done;
  int   done_cyc, fire_cyc, err_cyc, start_cyc;
  int   lat_cnt, bp_left, bp_seen;
  bit   valid_en;
  logic [15:0] bp_pix;
  logic err_prev;
  exp_t exp_q[$];

  mult_array_scheduler #(
    .bitsize  (14),
    .FRAC_BITS(7),
    .PIX_W    (16),
    .GRP_W    (8),
    .TIMEOUT  (64)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .cfg_start     (cfg_start),
    .cfg_num_pixels(cfg_num_pixels),
    .cfg_num_groups(cfg_num_groups),
    .w_req         (w_req),
    .w_ack         (w_ack),
    .x_req         (x_req),
    .x_ack         (x_ack),
    .mult_start    (mult_start),
    .mult_valid    (mult_valid),
    .res_valid     (res_valid),
    .res_ready     (res_ready),
    .pixel_idx     (pixel_idx),
    .group_idx     (group_idx),
    .busy          (busy),
    .done          (done),
    .err           (err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic check_quiet(input string tag);
    check_val({tag, "_flags"}, {25'd0, busy, done, err, w_req, x_req, mult_start, res_valid}, 0);
    check_val({tag, "_idx"}, {8'd0, group_idx, pixel_idx}, 0);
  endtask

  task automatic clear_counts();
    n_w = 0; n_x = 0; n_start = 0; n_hs = 0; n_done = 0;
  endtask

  // Drives a one-cycle cfg_start; returns one cycle later (#3 after the edge).
  task automatic start_run(input int np, input int ng, input bit push);
    exp_t e;
    cfg_num_pixels = 16'(np);
    cfg_num_groups = 8'(ng);
    if (push) begin
      for (int g = 0; g < ng; g++) begin
        for (int p = 0; p < np; p++) begin
          e.g = 8'(g);
          e.p = 16'(p);
          exp_q.push_back(e);
        end
      end
    end
    start_cyc = cyc;
    cfg_start = 1'b1;
    @(posedge clk); #3;
    cfg_start = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    int d0;
    int k;
    d0 = n_done;
    k = 0;
    while (n_done == d0 && k < budget) begin
      @(posedge clk); #3;
      k++;
    end
    check_val("done_seen", n_done - d0, 1);
  endtask

  // Responder + monitor: acks immediately, array latency Lat, optional stall.
  initial begin
    exp_t e;
    w_ack = 1'b0; x_ack = 1'b0; mult_valid = 1'b0; res_ready = 1'b1;
    cyc = 0; lat_cnt = 0; err_prev = 1'b0;
    forever begin
      @(posedge clk); #1;
      cyc++;
      if (!rst) begin
        w_ack = 1'b0; x_ack = 1'b0; mult_valid = 1'b0; lat_cnt = 0; err_prev = 1'b0;
      end else begin
        w_ack = w_req;
        if (w_req) n_w++;
        x_ack = x_req;
        if (x_req) n_x++;
        if (lat_cnt > 0) begin
          lat_cnt--;
          mult_valid = (lat_cnt == 0) && valid_en;
        end else begin
          mult_valid = 1'b0;
        end
        if (mult_start) begin
          n_start++;
          fire_cyc = cyc;
          lat_cnt = Lat;
        end
        res_ready = 1'b1;
        if (res_valid && bp_left > 0) begin
          if (bp_seen == 0) begin
            bp_pix = pixel_idx;
          end else begin
            check_val("bp_pix_hold", pixel_idx, bp_pix);
            check_val("bp_no_start", mult_start, 0);
          end
          bp_seen++;
          bp_left--;
          res_ready = 1'b0;
        end
        if (res_valid && res_ready) begin
          n_hs++;
          if (exp_q.size() == 0) begin
            check_val("sb_extra", exp_q.size(), 1);
          end else begin
            e = exp_q.pop_front();
            check_val("sb_grp", group_idx, e.g);
            check_val("sb_pix", pixel_idx, e.p);
          end
        end
        if (done) begin
          n_done++;
          done_cyc = cyc;
        end
        if (err && !err_prev) err_cyc = cyc;
        err_prev = err;
      end
    end
  end

  initial begin
    int cnp[2];
    int cng[2];
    int k;
    cnp[0] = 0; cng[0] = 3;
    cnp[1] = 4; cng[1] = 0;
    rst = 1'b0; cfg_start = 1'b0; cfg_num_pixels = '0; cfg_num_groups = '0;
    valid_en = 1'b1; bp_left = 0; bp_seen = 0; n_checks = 0; n_bad = 0;
    start_cyc = 0; done_cyc = 0; fire_cyc = 0; err_cyc = 0;
    clear_counts();

    repeat (3) @(posedge clk);
    #3;
    check_quiet("reset");
    rst = 1'b1;
    @(posedge clk); #3;

    // Full run 3 pixels x 2 groups, with an ignored second start while busy.
    clear_counts();
    start_run(3, 2, 1'b1);
    check_val("a_busy_c1", busy, 1);
    check_val("a_wreq_c1", w_req, 1);
    repeat (3) @(posedge clk);
    #3;
    cfg_num_pixels = 16'd9; cfg_num_groups = 8'd4; cfg_start = 1'b1;
    @(posedge clk); #3;
    cfg_start = 1'b0;
    wait_done(300);
    check_val("a_wreq_n", n_w, 2);
    check_val("a_xreq_n", n_x, 6);
    check_val("a_start_n", n_start, 6);
    check_val("a_hs_n", n_hs, 6);
    check_val("a_sb_empty", exp_q.size(), 0);
    check_val("a_busy_end", busy, 0);
    check_val("a_last_grp", group_idx, 1);
    check_val("a_last_pix", pixel_idx, 2);
    repeat (3) @(posedge clk);
    #3;
    check_val("a_one_done", n_done, 1);

    // Back-pressure: hold res_ready low for 5 cycles.
    clear_counts();
    bp_seen = 0; bp_left = 5;
    start_run(2, 1, 1'b1);
    wait_done(300);
    check_val("b_stall_cycles", bp_seen, 5);
    check_val("b_start_n", n_start, 2);
    check_val("b_hs_n", n_hs, 2);
    check_val("b_sb_empty", exp_q.size(), 0);
    repeat (2) @(posedge clk);
    #3;

    // Zero-count runs finish two cycles after start without any fetch.
    for (int i = 0; i < 2; i++) begin
      clear_counts();
      start_run(cnp[i], cng[i], 1'b0);
      wait_done(20);
      check_val("c_done_lat", done_cyc - start_cyc, 2);
      check_val("c_no_wreq", n_w, 0);
      check_val("c_no_xreq", n_x, 0);
      check_val("c_busy_end", busy, 0);
      repeat (2) @(posedge clk);
      #3;
    end

    // Array never responds: watchdog error, then a fresh start recovers.
    clear_counts();
    valid_en = 1'b0;
    start_run(1, 1, 1'b0);
    k = 0;
    while (!err && k < 200) begin
      @(posedge clk); #3;
      k++;
    end
    check_val("d_err_set", err, 1);
    check_val("d_err_lat", err_cyc - fire_cyc, 65);
    check_val("d_busy", busy, 0);
    check_val("d_reqs", {w_req, x_req, mult_start, res_valid}, 0);
    check_val("d_hs_n", n_hs, 0);
    valid_en = 1'b1;
    repeat (2) @(posedge clk);
    #3;
    check_val("d_err_sticky", err, 1);
    clear_counts();
    start_run(1, 1, 1'b1);
    check_val("d_err_clr", err, 0);
    check_val("d_busy_again", busy, 1);
    wait_done(100);
    check_val("d_hs_again", n_hs, 1);
    check_val("d_sb_empty", exp_q.size(), 0);
    repeat (2) @(posedge clk);
    #3;

    // Asynchronous reset in WAIT_MUL.
    clear_counts();
    start_run(2, 1, 1'b1);
    k = 0;
    while (n_start == 0 && k < 50) begin
      @(posedge clk); #3;
      k++;
    end
    check_val("e_fired", n_start, 1);
    @(posedge clk); #3;
    rst = 1'b0;
    #1;
    check_quiet("e_async");
    repeat (3) @(posedge clk);
    #3;
    check_quiet("e_held");
    check_val("e_no_done", n_done, 0);
    rst = 1'b1;
    exp_q.delete();
    @(posedge clk); #3;
    clear_counts();
    start_run(1, 1, 1'b1);
    wait_done(100);
    check_val("e_recover_hs", n_hs, 1);

    $display("test done: total=%0d bad=%0d", n_checks, n_bad);
    $finish;
  end

endmodule
